aes_key_schedule: RTL and testbench

- Sequential AES key-schedule engine for AES-128, AES-192 and AES-256, selected per job at run time.
- Expands the cipher key one 32-bit word per cycle and stores all Nr+1 round keys in an internal buffer.
- The cipher/decipher round datapath reads round keys by index through a registered read port.
- Replaces per-round combinational key expansion: one shared S-box word, no Rcon-index quirks, random access in both directions.

---
 rtl/aes_key_schedule_pkg.sv | 84 ++++++++
 rtl/aes_key_schedule_if.sv | 40 ++++
 rtl/aes_key_schedule_sub_word.sv | 18 +
 rtl/aes_key_schedule.sv | 186 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_schedule_pkg.sv
// +--------------------------------------------------------------------+
// | aes_key_pkg : S-box, key-length codes and helpers for key schedule |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package aes_key_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_RSV = 2'b11
  } key_len_e;

  localparam logic [7:0] S_BOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input key_len_e kl);
    logic [3:0] nk;
    case (kl)
      KL_192:  nk = 4'd6;
      KL_256:  nk = 4'd8;
      default: nk = 4'd4;
    endcase
    return nk;
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    logic [3:0] nr;
    case (kl)
      KL_192:  nr = 4'd12;
      KL_256:  nr = 4'd14;
      default: nr = 4'd10;
    endcase
    return nr;
  endfunction

  function automatic logic key_len_ok(input key_len_e kl, input int nk_max);
    logic ok;
    case (kl)
      KL_128:  ok = 1'b1;
      KL_192:  ok = (nk_max >= 6);
      KL_256:  ok = (nk_max >= 8);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // cols = {w0, w1, w2, w3}; byte r of word c lands at row r, column c
  function automatic logic [127:0] to_row_major(input logic [127:0] cols);
    logic [127:0] rm;
    rm = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rm[32*r + 8*c +: 8] = cols[127 - 32*c - 8*r -: 8];
      end
    end
    return rm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_schedule_if.sv
// +--------------------------------------------------------------------+
// | aes_key_schedule_if : control, status and read port of key schedule|
// | Option macro        : AES_KEY_SCHEDULE_ZEROIZE_EN adds zeroize     |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface aes_key_schedule_if #(
  parameter int NK_MAX = 8
);
  logic                  start;
  logic [1:0]            key_len;
  logic [NK_MAX*32-1:0]  key_in;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  logic                  zeroize;
`endif
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  keys_valid;
  logic [3:0]            num_rounds;
  logic                  rk_rd_en;
  logic [3:0]            rk_rd_idx;
  logic [127:0]          rk_rd_data;
  logic                  rk_rd_valid;

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  modport master (output start, key_len, key_in, zeroize, rk_rd_en, rk_rd_idx,
                  input  busy, done, err, keys_valid, num_rounds, rk_rd_data, rk_rd_valid);
  modport slave  (input  start, key_len, key_in, zeroize, rk_rd_en, rk_rd_idx,
                  output busy, done, err, keys_valid, num_rounds, rk_rd_data, rk_rd_valid);
`else
  modport master (output start, key_len, key_in, rk_rd_en, rk_rd_idx,
                  input  busy, done, err, keys_valid, num_rounds, rk_rd_data, rk_rd_valid);
  modport slave  (input  start, key_len, key_in, rk_rd_en, rk_rd_idx,
                  output busy, done, err, keys_valid, num_rounds, rk_rd_data, rk_rd_valid);
`endif
endinterface

`default_nettype wire

// File: rtl/aes_key_schedule_sub_word.sv
// +--------------------------------------------------------------------+
// | aes_sub_word : SubWord, four parallel S-box lookups on one word    |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module aes_sub_word
  import aes_key_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_out[8*b +: 8] = S_BOX[word_in[8*b +: 8]];
  end
endmodule

`default_nettype wire

// File: rtl/aes_key_schedule.sv
// +--------------------------------------------------------------------+
// | aes_key_schedule : word-serial AES-128/192/256 key expansion with  |
// |                    round-key buffer; option AES_KEY_SCHEDULE_ZEROIZE_EN
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module aes_key_schedule
  import aes_key_pkg::*;
#(
  parameter int NK_MAX   = 8,
  parameter int RK_DEPTH = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_schedule_if.slave  bus
);
  localparam int         c_words  = RK_DEPTH * 4;
  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_expand = 2'd1;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  localparam logic [1:0] c_clear  = 2'd2;
`endif

  logic [1:0]   r_state, w_state_nxt;
  logic [5:0]   r_idx;
  logic [2:0]   r_kpos;
  logic [3:0]   r_nk, r_nr, w_nk_new, w_old_sel;
  logic [7:0]   r_rcon;
  logic         r_done, r_err, r_keys_valid, r_rd_valid;
  logic [127:0] r_rd_data;
  logic [31:0]  r_win  [0:7];
  logic [31:0]  r_wmem [0:c_words-1];
  logic [31:0]  w_kw   [0:7];
  logic [31:0]  w_win_load [0:7];
  logic [31:0]  w_prev, w_old, w_sub_in, w_sub_out, w_temp, w_new;
  logic [3:0]   w_rd_row;
  logic [5:0]   w_rd_base;
  logic         w_busy, w_load, w_bad, w_step, w_last, w_start_ok, w_zero, w_rd_ok;
  key_len_e     w_kl;

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  logic w_clr_enter, w_clr;
  assign w_zero = bus.zeroize;
`else
  assign w_zero = 1'b0;
`endif

  assign w_kl       = key_len_e'(bus.key_len);
  assign w_start_ok = key_len_ok(w_kl, NK_MAX);
  assign w_nk_new   = nk_of(w_kl);
  assign w_last     = (r_idx == {r_nr, 2'b11});

  for (genvar k = 0; k < 8; k++) begin : g_kw
    if (k < NK_MAX) begin : g_used
      assign w_kw[k] = bus.key_in[NK_MAX*32-1-32*k -: 32];
    end else begin : g_pad
      assign w_kw[k] = '0;
    end
  end

  // Window keeps w[i-1] at slot 7 and w[i-Nk] at slot 8-Nk for every key size
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_win_load[j] = '0;
      if (j >= 8 - int'(w_nk_new)) w_win_load[j] = w_kw[3'(j + int'(w_nk_new) - 8)];
    end
  end

  assign w_prev    = r_win[7];
  assign w_old_sel = 4'd8 - r_nk;
  assign w_old     = r_win[w_old_sel[2:0]];
  assign w_sub_in  = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_in  (w_sub_in),
    .word_out (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_kpos == 3'd0)                       w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_kpos == 3'd4)  w_temp = w_sub_out;
  end
  assign w_new = w_old ^ w_temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (w_load) w_state_nxt = c_expand;
      c_expand: if (w_last) w_state_nxt = c_idle;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
      c_clear:  if (r_idx == 6'(RK_DEPTH - 1)) w_state_nxt = c_idle;
`endif
      default:  w_state_nxt = c_idle;
    endcase
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    if (w_clr_enter) w_state_nxt = c_clear;
`endif
  end

  always_comb begin
    w_busy = (r_state != c_idle);
    w_load = (r_state == c_idle) && bus.start && w_start_ok && !w_zero;
    w_bad  = (r_state == c_idle) && bus.start && !w_start_ok && !w_zero;
    w_step = (r_state == c_expand) && !w_zero;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    w_clr_enter = ((r_state == c_idle) || (r_state == c_expand)) && w_zero;
    w_clr       = (r_state == c_clear);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0; r_kpos <= '0; r_nk <= 4'd4; r_nr <= '0; r_rcon <= 8'h01;
      r_done <= 1'b0; r_err <= 1'b0; r_keys_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_bad;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
      if (w_clr_enter) begin
        r_idx <= '0; r_keys_valid <= 1'b0; r_nr <= '0;
      end else if (w_clr) begin
        r_idx <= r_idx + 6'd1;
      end else
`endif
      if (w_load) begin
        r_idx <= {2'b00, w_nk_new}; r_kpos <= '0; r_nk <= w_nk_new;
        r_rcon <= 8'h01; r_keys_valid <= 1'b0; r_nr <= nr_of(w_kl);
      end else if (w_step) begin
        r_idx  <= r_idx + 6'd1;
        r_kpos <= (r_kpos == 3'(r_nk - 4'd1)) ? 3'd0 : r_kpos + 3'd1;
        if (r_kpos == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last) begin
          r_done <= 1'b1; r_keys_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    if (w_clr) begin
      for (int c = 0; c < 4; c++) r_wmem[{r_idx[3:0], 2'(c)}] <= '0;
    end else
`endif
    if (w_load) begin
      for (int j = 0; j < 8; j++) r_win[j] <= w_win_load[j];
      for (int k = 0; k < 8; k++) if (k < int'(w_nk_new)) r_wmem[k] <= w_kw[k];
    end else if (w_step) begin
      for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
      r_win[7]      <= w_new;
      r_wmem[r_idx] <= w_new;
    end
  end

  assign w_rd_ok   = bus.rk_rd_en && r_keys_valid && (bus.rk_rd_idx <= r_nr);
  assign w_rd_row  = (int'(bus.rk_rd_idx) < RK_DEPTH) ? bus.rk_rd_idx : 4'd0;
  assign w_rd_base = {w_rd_row, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0; r_rd_data <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_data  <= w_rd_ok ? to_row_major({r_wmem[w_rd_base],        r_wmem[w_rd_base + 6'd1],
                                            r_wmem[w_rd_base + 6'd2], r_wmem[w_rd_base + 6'd3]})
                            : '0;
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.keys_valid  = r_keys_valid;
  assign bus.num_rounds  = r_nr;
  assign bus.rk_rd_data  = r_rd_data;
  assign bus.rk_rd_valid = r_rd_valid;
endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
// +--------------------------------------------------------------------+
// | tb_aes_key_schedule : FIPS-197 vectors plus random keys vs a model |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  aes_key_schedule_if #(.NK_MAX(8)) bus ();
  aes_key_schedule #(.NK_MAX(8), .RK_DEPTH(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [7:0]  sbox_m [0:255];
  logic [31:0] mw [0:59];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] x = b;
    for (int k = 0; k < n; k++) x = {x[6:0], x[7]};
    return x;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rm(input logic [31:0] c0, c1, c2, c3);
    logic [31:0]  w [4];
    logic [127:0] o = '0;
    w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[32*r + 8*c +: 8] = w[c][31 - 8*r -: 8];
    return o;
  endfunction

  function automatic logic [31:0] col3(input logic [127:0] d);
    return {d[31:24], d[63:56], d[95:88], d[127:120]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input int idx, output logic [127:0] d, output logic v);
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'(idx);
    tick();
    d = bus.rk_rd_data; v = bus.rk_rd_valid;
    bus.rk_rd_en = 1'b0;
  endtask

  // Returns at the done cycle; restart_at>0 re-asserts start (reserved key_len) in that cycle
  task automatic run_job(input logic [255:0] key, input logic [1:0] kl, input int restart_at,
                         output int lat, output bit busy_ok, output bit err_seen);
    bus.key_in = key; bus.key_len = kl; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; lat = 1; busy_ok = 1'b1; err_seen = 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.err  !== 1'b0) err_seen = 1'b1;
      bus.start = (lat == restart_at);
      if (lat == restart_at) begin bus.key_len = 2'b11; bus.key_in = ~key; end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    if (lat >= 200) lat = -1;
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] d; logic v;
    if ({bus.busy, bus.done, bus.err, bus.keys_valid} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.err, bus.keys_valid}); n_bad++;
    end
    n_cmp++;
    if (bus.num_rounds !== 4'd0) begin $display("FAIL reset_nr: got %0d want 0", bus.num_rounds); n_bad++; end
    n_cmp++;
    rd(0, d, v);
    if (v !== 1'b0 || d !== '0) begin $display("FAIL reset_read: got v=%b d=%h want 0", v, d); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_fips128();
    int lat; bit bok, es; logic [127:0] d; logic v;
    model_expand(KEY_A1, 4);
    run_job(KEY_A1, 2'b00, 0, lat, bok, es);
    if (lat !== 41) begin $display("FAIL a1_latency: got %0d want 41", lat); n_bad++; end
    n_cmp++;
    if (!bok) begin $display("FAIL a1_busy: busy profile wrong, got 0 want 1"); n_bad++; end
    n_cmp++;
    if (bus.keys_valid !== 1'b1 || bus.num_rounds !== 4'd10) begin
      $display("FAIL a1_status: got kv=%b nr=%0d want kv=1 nr=10", bus.keys_valid, bus.num_rounds); n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.done !== 1'b0) begin $display("FAIL a1_done_pulse: got %b want 0", bus.done); n_bad++; end
    n_cmp++;
    rd(10, d, v);
    if (v !== 1'b1 || d !== rm(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6)) begin
      $display("FAIL a1_rk10: got v=%b d=%h", v, d); n_bad++;
    end
    n_cmp++;
    rd(0, d, v);
    if (v !== 1'b1 || d !== rm(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c)) begin
      $display("FAIL a1_rk0: got v=%b d=%h", v, d); n_bad++;
    end
    n_cmp++;
    rd(5, d, v);
    if (v !== 1'b1 || d !== rm(mw[20], mw[21], mw[22], mw[23])) begin
      $display("FAIL a1_rk5: got v=%b d=%h want %h", v, d, rm(mw[20], mw[21], mw[22], mw[23])); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_fips192();
    int lat; bit bok, es; logic [127:0] d; logic v;
    run_job(KEY_A2, 2'b01, 0, lat, bok, es);
    if (lat !== 47 || bus.num_rounds !== 4'd12) begin
      $display("FAIL a2_latency_nr: got lat=%0d nr=%0d want 47/12", lat, bus.num_rounds); n_bad++;
    end
    n_cmp++;
    rd(12, d, v);
    if (v !== 1'b1 || col3(d) !== 32'h01002202) begin
      $display("FAIL a2_rk12_col3: got v=%b col=%h want 01002202", v, col3(d)); n_bad++;
    end
    n_cmp++;
    rd(13, d, v);
    if (v !== 1'b0 || d !== '0) begin $display("FAIL a2_rk13_oob: got v=%b d=%h want 0", v, d); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_fips256_illegal();
    int lat; bit bok, es; logic [127:0] d; logic v;
    run_job(KEY_A3, 2'b10, 0, lat, bok, es);
    if (lat !== 53) begin $display("FAIL a3_latency: got %0d want 53", lat); n_bad++; end
    n_cmp++;
    rd(14, d, v);
    if (v !== 1'b1 || col3(d) !== 32'h706c631e) begin
      $display("FAIL a3_rk14_col3: got v=%b col=%h want 706c631e", v, col3(d)); n_bad++;
    end
    n_cmp++;
    bus.key_len = 2'b11; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL illegal_err: got err=%b busy=%b want 1/0", bus.err, bus.busy); n_bad++;
    end
    n_cmp++;
    tick();
    if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.keys_valid !== 1'b1 || bus.num_rounds !== 4'd14) begin
      $display("FAIL illegal_after: got err=%b busy=%b kv=%b nr=%0d want 0/0/1/14",
               bus.err, bus.busy, bus.keys_valid, bus.num_rounds); n_bad++;
    end
    n_cmp++;
    rd(14, d, v);
    if (v !== 1'b1 || col3(d) !== 32'h706c631e) begin
      $display("FAIL illegal_keeps: got v=%b col=%h want 706c631e", v, col3(d)); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_start_during_expand();
    int lat; bit bok, es; logic [127:0] d; logic v;
    model_expand(KEY_A2, 6);
    run_job(KEY_A2, 2'b01, 10, lat, bok, es);
    if (lat !== 47 || es) begin $display("FAIL restart_ignored: got lat=%0d err=%b want 47/0", lat, es); n_bad++; end
    n_cmp++;
    rd(7, d, v);
    if (v !== 1'b1 || d !== rm(mw[28], mw[29], mw[30], mw[31])) begin
      $display("FAIL restart_rk7: got v=%b d=%h want %h", v, d, rm(mw[28], mw[29], mw[30], mw[31])); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_expand();
    bus.key_in = KEY_A3; bus.key_len = 2'b10; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 19; c++) tick();
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd0;
    tick();
    bus.rk_rd_en = 1'b0;
    if (bus.rk_rd_valid !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL expand_read: got v=%b busy=%b want 0/1", bus.rk_rd_valid, bus.busy); n_bad++;
    end
    n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if ({bus.busy, bus.done, bus.err, bus.keys_valid, bus.rk_rd_valid} !== 5'b0 ||
        bus.num_rounds !== 4'd0 || bus.rk_rd_data !== '0) begin
      $display("FAIL async_reset: got flags=%b nr=%0d want 0", {bus.busy, bus.done, bus.err, bus.keys_valid,
               bus.rk_rd_valid}, bus.num_rounds); n_bad++;
    end
    n_cmp++;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int lat; bit bok, es; logic [127:0] d; logic v;
    for (int j = 0; j < 6; j++) begin
      logic [255:0] key;
      int kl, nk;
      for (int w = 0; w < 8; w++) key[32*w +: 32] = $urandom;
      kl = $urandom_range(0, 2);
      nk = 4 + 2*kl;
      model_expand(key, nk);
      run_job(key, 2'(kl), 0, lat, bok, es);
      if (lat !== 3*nk + 29 || bus.num_rounds !== 4'(nk + 6)) begin
        $display("FAIL rand_job%0d: got lat=%0d nr=%0d want %0d/%0d", j, lat, bus.num_rounds, 3*nk+29, nk+6); n_bad++;
      end
      n_cmp++;
      for (int k = 0; k <= nk + 6; k++) begin
        rd(k, d, v);
        if (v !== 1'b1 || d !== rm(mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3])) begin
          $display("FAIL rand_rk%0d_%0d: got v=%b d=%h want %h", j, k, v, d,
                   rm(mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3])); n_bad++;
        end
        n_cmp++;
      end
      rd(nk + 7, d, v);
      if (v !== 1'b0 || d !== '0) begin $display("FAIL rand_oob%0d: got v=%b d=%h want 0", j, v, d); n_bad++; end
      n_cmp++;
    end
  endtask

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  task automatic test_zeroize();
    int busy_cycles = 0; logic [127:0] d; logic v;
    bit bok, es; int lat;
    run_job(KEY_A1, 2'b00, 0, lat, bok, es);
    bus.zeroize = 1'b1;
    tick();
    bus.zeroize = 1'b0;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      if (bus.keys_valid !== 1'b0 || bus.num_rounds !== 4'd0) busy_cycles += 1000;
      busy_cycles++;
      tick();
    end
    if (busy_cycles !== 15 || bus.done !== 1'b0) begin
      $display("FAIL zeroize_busy: got %0d done=%b want 15/0", busy_cycles, bus.done); n_bad++;
    end
    n_cmp++;
    rd(0, d, v);
    if (v !== 1'b0 || bus.keys_valid !== 1'b0) begin
      $display("FAIL zeroize_read: got v=%b kv=%b want 0/0", v, bus.keys_valid); n_bad++;
    end
    n_cmp++;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0;
    bus.rk_rd_en = 1'b0; bus.rk_rd_idx = 4'd0;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    bus.zeroize = 1'b0;
`endif
    build_sbox();
    #23 rst_n = 1'b1;
    tick();
    test_reset();
    test_fips128();
    test_fips192();
    test_fips256_illegal();
    test_start_during_expand();
    test_reset_mid_expand();
    test_reset();
    test_fips128();
    test_random();
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    test_zeroize();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
